pio_blink_out: RTL
==================

Name: pio_blink_out

Overview:
Avalon-MM slave output PIO. It is the write-side counterpart of the button/edge-capture input PIOs and drives LEDs and the buzzer in the alarm system.
- Holds a data register with atomic set and clear aliases.
- Adds a per-bit hardware blink generator with a programmable half-period.
- Optional finite pulse count, which raises irq when the count is exhausted.
- Lets the Nios firmware start a timed alarm pattern and forget it.

Parameters:
WIDTH, 8, number of output bits on out_port (1..32).
PERIOD_W, 24, width of the half-period register and tick counter.
CNT_W, 16, width of the pulse-count register.

Ports:
clk  input  1  system clock, single domain.
reset_n  input  1  asynchronous, active-low reset.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe.
writedata  input  32  write data; upper unused bits ignored.
readdata  output  32  registered read data, zero-extended.
out_port  output  WIDTH  registered output pins.
irq  output  1  level interrupt = done & irq_en.

Behaviour:
- Write occurs when chipselect & ~write_n. Reads are not gated by chipselect.
- readdata <= mux(address) on every clk, giving 1-cycle read latency. Unused and write-only addresses read 0.
- Register map:
  - 0 DATA (R/W).
  - 1 BLINK_EN (R/W, per-bit mask).
  - 2 PERIOD (R/W, half-period in clocks).
  - 3 PULSE (R/W; read returns the remaining count).
  - 4 OUTSET (W: data |= wd).
  - 5 OUTCLEAR (W: data &= ~wd).
  - 6 CONTROL (R/W, bit0 irq_en).
  - 7 STATUS (R: bit0 phase, bit1 done; any write clears done).
- Reset values:
  - data, blink_en, period, pulse, irq_en, done all 0.
  - cnt 0, phase 1.
  - out_port 0, readdata 0, irq 0.
- Blink timer:
  - Active when period != 0 and blink_en != 0.
  - When active: if cnt == period-1, cnt <= 0 and phase toggles; else cnt++.
  - When inactive: cnt <= 0 and phase <= 1.
- Writes to PERIOD or PULSE force cnt <= 0 and phase <= 1 in that same cycle, restarting the pattern with the "on" half.
- Pulse counting:
  - A full blink cycle completes on the phase 0->1 toggle.
  - On that toggle, if pulse > 1: pulse--.
  - If pulse == 1: pulse <= 0, blink_en <= 0, done <= 1.
  - pulse == 0 means continuous blinking, never decremented.
- Simultaneity rules:
  - A bus write to BLINK_EN or PULSE in the same cycle as pulse exhaustion wins over the hardware update.
  - A STATUS write in the same cycle as exhaustion leaves done = 1 (set wins).
- Output: out_port <= data & ~(blink_en & {WIDTH{~phase}}).
  - Non-blinking bits follow data.
  - Blinking bits show data during phase 1 and 0 during phase 0.
  - Latency: 1 clk after the register update.
- Only the low WIDTH/PERIOD_W/CNT_W bits of writedata are stored.
- Reset asserted mid-pattern returns all state to reset values immediately. Blinking does not resume after reset.

Decomposition:
- Shared package: register address constants (ADDR_DATA..ADDR_STATUS), STATUS bit indices, CONTROL bit index.
- One natural sub-module: pio_blink_timer.
  - Contains cnt, phase, pulse counter and exhaustion detect.
  - Inputs: period, start/restart, active, pulse load.
  - Outputs: phase, pulse_remaining, exhaust strobe.
- Top level keeps the register file, read mux and output register.

Test Plan:
- Reset, then read addresses 0..7 -> readdata 0 except STATUS = 0x1 (phase 1); out_port = 0, irq = 0.
- Write DATA=0xA5, then OUTSET=0x02, then OUTCLEAR=0x80 -> DATA reads 0x27; out_port = 0x27 one clk after the last write.
- DATA=0x01, PERIOD=4, BLINK_EN=0x01, PULSE=0 -> out_port[0] is 1 for 4 clks then 0 for 4 clks, repeating indefinitely; PULSE reads 0.
- CONTROL=1, DATA=0x01, PERIOD=4, BLINK_EN=0x01, PULSE=2:
  - out_port[0] blinks exactly 2 cycles (16 clks).
  - Then BLINK_EN reads 0, STATUS bit1 = 1, irq = 1, out_port[0] holds 1.
  - Write STATUS -> irq = 0.
- PERIOD=0 with BLINK_EN=0x01, DATA=0x01 -> phase held 1, out_port[0] steady 1, done never sets.
- Write PULSE mid-blink while phase = 0 -> next clk phase = 1, cnt = 0; blinking restarts with the new count.
- Assert reset_n low mid-blink -> out_port = 0 and irq = 0 immediately; no blinking after release.

Source files
------------

// File: rtl/pio_blink_out_pkg.sv
// Shared register map and bit positions for the pio_blink_out output PIO.
// Also holds a small helper that packs the STATUS word.
package pio_blink_out_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_BLINK_EN = 3'd1,
        ADDR_PERIOD   = 3'd2,
        ADDR_PULSE    = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5,
        ADDR_CONTROL  = 3'd6,
        ADDR_STATUS   = 3'd7
    } reg_addr_e;

    localparam int STATUS_PHASE_BIT   = 0;
    localparam int STATUS_DONE_BIT    = 1;
    localparam int CONTROL_IRQ_EN_BIT = 0;

    function automatic logic [31:0] status_word(input logic phase, input logic done);
        logic [31:0] w;
        w                  = 32'd0;
        w[STATUS_PHASE_BIT] = phase;
        w[STATUS_DONE_BIT]  = done;
        return w;
    endfunction

endpackage

// File: rtl/pio_blink_out_if.sv
// Avalon-MM slave bus bundle for pio_blink_out.
interface pio_blink_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_blink_out_timer.sv
// Half-period tick counter, blink phase and finite pulse counter.
// exhaust is a combinational strobe on the phase 0->1 toggle that consumes the last pulse.
module pio_blink_timer #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                active,
    input  logic                restart,
    input  logic                pulse_load,
    input  logic [CNT_W-1:0]    pulse_wdata,
    output logic                phase,
    output logic [CNT_W-1:0]    pulse_remaining,
    output logic                exhaust
);

    logic [PERIOD_W-1:0] cnt_r;
    logic                phase_r;
    logic [CNT_W-1:0]    pulse_r;
    logic                wrap_s;
    logic                cycle_done_s;

    // Wrap, full-cycle and exhaustion detect; a restart suppresses all of them.
    always_comb begin
        wrap_s       = 1'b0;
        cycle_done_s = 1'b0;
        exhaust      = 1'b0;
        if (active && !restart) begin
            wrap_s = (cnt_r == (period - PERIOD_W'(1)));
        end else begin
            wrap_s = 1'b0;
        end
        cycle_done_s = wrap_s & ~phase_r;
        exhaust      = cycle_done_s & (pulse_r == CNT_W'(1));
    end

    // Tick counter and phase; idle or restarted patterns sit at the start of the "on" half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= 1'b1;
        end else if (restart || !active) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= 1'b1;
        end else if (wrap_s) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + PERIOD_W'(1);
            phase_r <= phase_r;
        end
    end

    // Remaining pulse count; zero means blink forever and is never decremented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_r <= {CNT_W{1'b0}};
        end else if (pulse_load) begin
            pulse_r <= pulse_wdata;
        end else if (exhaust) begin
            pulse_r <= {CNT_W{1'b0}};
        end else if (cycle_done_s && (pulse_r > CNT_W'(1))) begin
            pulse_r <= pulse_r - CNT_W'(1);
        end else begin
            pulse_r <= pulse_r;
        end
    end

    assign phase           = phase_r;
    assign pulse_remaining = pulse_r;

endmodule

// File: rtl/pio_blink_out.sv
// Avalon-MM output PIO with set/clear aliases, per-bit blink and a finite pulse count.
// Register file, read mux and registered pins live here; timing lives in pio_blink_timer.
module pio_blink_out
    import pio_blink_out_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_blink_out_if.slave       bus,
    output logic [WIDTH-1:0]     out_port,
    output logic                 irq
);

    logic [WIDTH-1:0]    data_r;
    logic [WIDTH-1:0]    blink_en_r;
    logic [PERIOD_W-1:0] period_r;
    logic                irq_en_r;
    logic                done_r;

    logic                we_s;
    logic                wr_data_s;
    logic                wr_blink_s;
    logic                wr_period_s;
    logic                wr_pulse_s;
    logic                wr_set_s;
    logic                wr_clear_s;
    logic                wr_control_s;
    logic                wr_status_s;
    logic                active_s;
    logic                phase_s;
    logic                exhaust_s;
    logic [CNT_W-1:0]    pulse_rem_s;
    logic                done_nxt_s;
    logic                irq_en_nxt_s;
    logic [31:0]         rd_mux_s;
    logic [WIDTH-1:0]    wd_bits_s;
    logic                unused_wd_s;

    assign we_s        = bus.chipselect & ~bus.write_n;
    assign wd_bits_s   = bus.writedata[WIDTH-1:0];
    assign active_s    = (period_r != {PERIOD_W{1'b0}}) && (blink_en_r != {WIDTH{1'b0}});
    assign unused_wd_s = ^bus.writedata;

    // Write-strobe decode per register.
    always_comb begin
        wr_data_s    = 1'b0;
        wr_blink_s   = 1'b0;
        wr_period_s  = 1'b0;
        wr_pulse_s   = 1'b0;
        wr_set_s     = 1'b0;
        wr_clear_s   = 1'b0;
        wr_control_s = 1'b0;
        wr_status_s  = 1'b0;
        case (bus.address)
            ADDR_DATA:     wr_data_s    = we_s;
            ADDR_BLINK_EN: wr_blink_s   = we_s;
            ADDR_PERIOD:   wr_period_s  = we_s;
            ADDR_PULSE:    wr_pulse_s   = we_s;
            ADDR_OUTSET:   wr_set_s     = we_s;
            ADDR_OUTCLEAR: wr_clear_s   = we_s;
            ADDR_CONTROL:  wr_control_s = we_s;
            ADDR_STATUS:   wr_status_s  = we_s;
            default:       wr_data_s    = 1'b0;
        endcase
    end

    pio_blink_timer #(
        .PERIOD_W (PERIOD_W),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk             (clk),
        .reset_n         (reset_n),
        .period          (period_r),
        .active          (active_s),
        .restart         (wr_period_s | wr_pulse_s),
        .pulse_load      (wr_pulse_s),
        .pulse_wdata     (bus.writedata[CNT_W-1:0]),
        .phase           (phase_s),
        .pulse_remaining (pulse_rem_s),
        .exhaust         (exhaust_s)
    );

    // Next done / irq_en; exhaustion beats a same-cycle STATUS clear.
    always_comb begin
        done_nxt_s   = done_r;
        irq_en_nxt_s = irq_en_r;
        if (exhaust_s) begin
            done_nxt_s = 1'b1;
        end else if (wr_status_s) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end
        if (wr_control_s) begin
            irq_en_nxt_s = bus.writedata[CONTROL_IRQ_EN_BIT];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
    end

    // Read mux; write-only and unused addresses return zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (bus.address)
            ADDR_DATA:     rd_mux_s = 32'(data_r);
            ADDR_BLINK_EN: rd_mux_s = 32'(blink_en_r);
            ADDR_PERIOD:   rd_mux_s = 32'(period_r);
            ADDR_PULSE:    rd_mux_s = 32'(pulse_rem_s);
            ADDR_CONTROL:  rd_mux_s = {31'd0, irq_en_r};
            ADDR_STATUS:   rd_mux_s = status_word(phase_s, done_r);
            default:       rd_mux_s = 32'd0;
        endcase
    end

    // DATA register with atomic set/clear aliases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= {WIDTH{1'b0}};
        end else if (wr_data_s) begin
            data_r <= wd_bits_s;
        end else if (wr_set_s) begin
            data_r <= data_r | wd_bits_s;
        end else if (wr_clear_s) begin
            data_r <= data_r & ~wd_bits_s;
        end else begin
            data_r <= data_r;
        end
    end

    // BLINK_EN mask; a bus write overrides the auto-clear on exhaustion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_en_r <= {WIDTH{1'b0}};
        end else if (wr_blink_s) begin
            blink_en_r <= wd_bits_s;
        end else if (exhaust_s) begin
            blink_en_r <= {WIDTH{1'b0}};
        end else begin
            blink_en_r <= blink_en_r;
        end
    end

    // PERIOD, CONTROL and STATUS state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_r <= {PERIOD_W{1'b0}};
            irq_en_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            period_r <= wr_period_s ? bus.writedata[PERIOD_W-1:0] : period_r;
            irq_en_r <= irq_en_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Registered bus read data, pins and interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= 32'd0;
            out_port     <= {WIDTH{1'b0}};
            irq          <= 1'b0;
        end else begin
            bus.readdata <= rd_mux_s;
            out_port     <= data_r & ~(blink_en_r & {WIDTH{~phase_s}});
            irq          <= done_nxt_s & irq_en_nxt_s;
        end
    end

endmodule
